// File: rtl/llr_frame_loader.sv
// llr_frame_loader: serial channel-LLR input stage for the LDPC decoder.
// Accepts one LLR per cycle over valid/ready, quantises it to data_w bits and
// assembles R*D-sample frames into two ping-pong banks. Completed frames are
// presented on l_out with a frame_valid/frame_done handshake.
// Optional feature: define LLR_SAT_EN to saturate samples symmetrically to
// +/-(2^(data_w-1)-1); otherwise the low data_w bits are used as-is.
module llr_frame_loader #(
   parameter int R      = 24,
   parameter int D      = 24,
   parameter int data_w = 12,
   parameter int in_w   = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [in_w-1:0]          llr_in,
   input  logic                     llr_valid,
   input  logic                     llr_sof,
   output logic                     llr_ready,
   output logic [R*D*data_w-1:0]    l_out,
   output logic                     frame_valid,
   input  logic                     frame_done,
   output logic                     sync_err
);

   localparam int N     = R * D;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

   typedef enum logic [1:0] {IDLE, PRESENT, GAP} rd_state_t;

   logic [N*data_w-1:0] bank [2];
   logic                wr_bank;
   logic                rd_bank;
   logic [IDX_W-1:0]    wr_idx;
   logic [IDX_W-1:0]    wr_k;
   logic [IDX_W-1:0]    wr_slot;
   logic [1:0]          full;
   logic                accept;
   logic                release_bank;
   logic [data_w-1:0]   q;
   rd_state_t           state;
   rd_state_t           state_next;

   // The write bank is writable only while it is not holding a finished frame.
   assign llr_ready = ~full[wr_bank];
   assign accept    = llr_valid & llr_ready;
   // A start-of-frame always restarts at sample 0, discarding any partial frame.
   assign wr_k      = llr_sof ? '0 : wr_idx;
   // Sample k lands at slot N-1-k so the first sample ends up in the MSBs.
   assign wr_slot   = LAST - wr_k;
   assign l_out     = bank[rd_bank];

`ifdef LLR_SAT_EN
   localparam int SAT_MAX_I = (1 << (data_w - 1)) - 1;
   localparam logic signed [in_w-1:0] SAT_HI = in_w'(SAT_MAX_I);
   localparam logic signed [in_w-1:0] SAT_LO = in_w'(-SAT_MAX_I);

   // Symmetric clamp; the most negative data_w code is never produced.
   always_comb begin
      if ($signed(llr_in) > SAT_HI)
         q = SAT_HI[data_w-1:0];
      else if ($signed(llr_in) < SAT_LO)
         q = SAT_LO[data_w-1:0];
      else
         q = llr_in[data_w-1:0];
   end
`else
   assign q = llr_in[data_w-1:0];

   // Upper input bits are intentionally dropped by truncation.
   if (in_w > data_w) begin : g_unused_hi
      logic unused_hi;
      assign unused_hi = ^llr_in[in_w-1:data_w];
   end
`endif

   // Write pointer, bank select and resynchronisation flag.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         wr_bank  <= 1'b0;
         wr_idx   <= '0;
         sync_err <= 1'b0;
      end else begin
         sync_err <= accept & llr_sof & (wr_idx != '0);
         if (accept) begin
            if (wr_k == LAST) begin
               wr_bank <= ~wr_bank;
               wr_idx  <= '0;
            end else begin
               wr_idx <= wr_k + 1'b1;
            end
         end
      end
   end

   // Frame storage: one data_w word written per accepted sample.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: the banks drive l_out directly, so they are reset to give the
      // decoder a defined all-zero frame out of reset.
      if (rst) begin
         bank[0] <= '0;
         bank[1] <= '0;
      end else if (accept) begin
         bank[wr_bank][wr_slot*data_w +: data_w] <= q;
      end
   end

   // Bank occupancy: set by the writer on the last sample, cleared by the reader
   // on release. They never target the same bank on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full <= 2'b00;
      end else begin
         if (accept && (wr_k == LAST))
            full[wr_bank] <= 1'b1;
         if (release_bank)
            full[rd_bank] <= 1'b0;
      end
   end

   // Read-side state register and read bank pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         rd_bank <= 1'b0;
      end else begin
         state <= state_next;
         if (release_bank)
            rd_bank <= ~rd_bank;
      end
   end

   // Read-side next state and handshake outputs.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves one unassigned
      // and no latch is inferred.
      state_next   = state;
      frame_valid  = 1'b0;
      release_bank = 1'b0;
      case (state)
         IDLE: begin
            if (full[rd_bank])
               state_next = PRESENT;
         end
         PRESENT: begin
            frame_valid = 1'b1;
            if (frame_done) begin
               release_bank = 1'b1;
               state_next   = GAP;
            end
         end
         GAP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_llr_frame_loader.sv
// Directed self-checking bench for llr_frame_loader (default parameters).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_llr_frame_loader;

   localparam int R      = 24;
   localparam int D      = 24;
   localparam int data_w = 12;
   localparam int in_w   = 16;
   localparam int N      = R * D;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [in_w-1:0]       llr_in;
   logic                  llr_valid;
   logic                  llr_sof;
   logic                  llr_ready;
   logic [N*data_w-1:0]   l_out;
   logic                  frame_valid;
   logic                  frame_done;
   logic                  sync_err;

   int n_checks = 0;
   int n_fail   = 0;

   llr_frame_loader #(.R(R), .D(D), .data_w(data_w), .in_w(in_w)) dut (
      .clk         (clk),
      .rst         (rst),
      .llr_in      (llr_in),
      .llr_valid   (llr_valid),
      .llr_sof     (llr_sof),
      .llr_ready   (llr_ready),
      .l_out       (l_out),
      .frame_valid (frame_valid),
      .frame_done  (frame_done),
      .sync_err    (sync_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Word for sample k of the presented frame.
   function automatic logic [data_w-1:0] word(input int k);
      return l_out[(N-1-k)*data_w +: data_w];
   endfunction

   function automatic logic [data_w-1:0] w12(input int v);
      return data_w'(v);
   endfunction

   // Present one sample for one cycle once the loader is ready.
   task automatic push(input int v, input logic sof);
      int n = 0;
      while (!llr_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (!llr_ready)
         check("ready_timeout", 32'(llr_ready), 32'd1);
      llr_in    = in_w'(v);
      llr_sof   = sof;
      llr_valid = 1'b1;
      @(negedge clk);
      llr_valid = 1'b0;
      llr_sof   = 1'b0;
   endtask

   task automatic pulse_done();
      frame_done = 1'b1;
      @(negedge clk);
      frame_done = 1'b0;
   endtask

   initial begin
      rst        = 1'b1;
      llr_in     = '0;
      llr_valid  = 1'b0;
      llr_sof    = 1'b0;
      frame_done = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_frame_valid", 32'(frame_valid), 32'd0);
      check("rst_sync_err", 32'(sync_err), 32'd0);
      check("rst_ready", 32'(llr_ready), 32'd1);
      check("rst_l_out_zero", 32'(|l_out), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Frame of k-288 with sof on the first sample.
      push(-288, 1'b1);
      check("sof_normal_no_err", 32'(sync_err), 32'd0);
      for (int k = 1; k < N; k++) push(k - 288, 1'b0);
      check("t1_valid_latency0", 32'(frame_valid), 32'd0);
      @(negedge clk);
      check("t1_valid", 32'(frame_valid), 32'd1);
      check("t1_first_msb", 32'(word(0)), 32'(w12(-288)));
      check("t1_last_lsb", 32'(l_out[11:0]), 32'(w12(287)));
      check("t1_mid", 32'(word(100)), 32'(w12(-188)));
      check("t1_ready_other_bank", 32'(llr_ready), 32'd1);
      pulse_done();
      check("t1_gap", 32'(frame_valid), 32'd0);
      @(negedge clk);
      check("t1_idle", 32'(frame_valid), 32'd0);

      // frame_done while IDLE must be ignored.
      pulse_done();
      check("idle_done_ignored", 32'(frame_valid), 32'd0);

      // Three frames back to back; A = k+1, B = -(k+1), C = 2k-500.
      for (int k = 0; k < N; k++) push(k + 1, k == 0);
      for (int k = 0; k < N; k++) push(-(k + 1), k == 0);
      check("bp_ready_low", 32'(llr_ready), 32'd0);
      check("bp_valid_a", 32'(frame_valid), 32'd1);
      check("bp_a_first", 32'(word(0)), 32'(w12(1)));
      check("bp_a_last", 32'(word(N-1)), 32'(w12(N)));
      // Hold C's first sample while releasing A.
      llr_in     = in_w'(-500);
      llr_sof    = 1'b1;
      llr_valid  = 1'b1;
      frame_done = 1'b1;
      @(negedge clk);
      check("rel_gap", 32'(frame_valid), 32'd0);
      check("rel_ready_up", 32'(llr_ready), 32'd1);
      frame_done = 1'b1;   // lands in GAP, must be ignored
      @(negedge clk);
      frame_done = 1'b0;
      llr_valid  = 1'b0;
      llr_sof    = 1'b0;
      check("rel_idle", 32'(frame_valid), 32'd0);
      check("rel_c0_no_sync_err", 32'(sync_err), 32'd0);
      @(negedge clk);
      check("rel_valid_b", 32'(frame_valid), 32'd1);
      check("rel_b_first", 32'(word(0)), 32'(w12(-1)));
      check("rel_b_last", 32'(word(N-1)), 32'(w12(-N)));
      for (int k = 1; k < N; k++) push(2 * k - 500, 1'b0);
      check("c_ready_low", 32'(llr_ready), 32'd0);
      check("c_still_b", 32'(word(0)), 32'(w12(-1)));
      pulse_done();
      repeat (2) @(negedge clk);
      check("c_valid", 32'(frame_valid), 32'd1);
      check("c_first", 32'(word(0)), 32'(w12(-500)));
      check("c_last", 32'(word(N-1)), 32'(w12(2 * (N-1) - 500)));
      pulse_done();
      repeat (2) @(negedge clk);
      check("c_released", 32'(frame_valid), 32'd0);

      // Resynchronisation: 100 stale samples then a fresh sof frame (3k-800).
      for (int k = 0; k < 100; k++) push(7, k == 0);
      push(-800, 1'b1);
      check("sync_err_pulse", 32'(sync_err), 32'd1);
      push(-797, 1'b0);
      check("sync_err_one_cycle", 32'(sync_err), 32'd0);
      for (int k = 2; k < N; k++) push(3 * k - 800, 1'b0);
      @(negedge clk);
      check("sync_valid", 32'(frame_valid), 32'd1);
      check("sync_first", 32'(word(0)), 32'(w12(-800)));
      check("sync_k99", 32'(word(99)), 32'(w12(3 * 99 - 800)));
      check("sync_last", 32'(word(N-1)), 32'(w12(3 * (N-1) - 800)));
      pulse_done();
      repeat (2) @(negedge clk);

      // Quantisation corners.
      push(32'h1805, 1'b1);
      push(30000, 1'b0);
      push(-32768, 1'b0);
      push(-2048, 1'b0);
      push(2047, 1'b0);
      for (int k = 5; k < N; k++) push(0, 1'b0);
      @(negedge clk);
      check("q_valid", 32'(frame_valid), 32'd1);
`ifdef LLR_SAT_EN
      check("q_1805", 32'(word(0)), 32'h7ff);
      check("q_30000", 32'(word(1)), 32'h7ff);
      check("q_neg32768", 32'(word(2)), 32'h801);
      check("q_neg2048", 32'(word(3)), 32'h801);
`else
      check("q_1805", 32'(word(0)), 32'h805);
      check("q_30000", 32'(word(1)), 32'h530);
      check("q_neg32768", 32'(word(2)), 32'h000);
      check("q_neg2048", 32'(word(3)), 32'h800);
`endif
      check("q_2047", 32'(word(4)), 32'h7ff);
      pulse_done();
      repeat (2) @(negedge clk);

      // Reset in the middle of a frame.
      for (int k = 0; k < 300; k++) push(9, k == 0);
      rst = 1'b1;
      #1;
      check("rst_mid_frame_valid", 32'(frame_valid), 32'd0);
      check("rst_mid_frame_ready", 32'(llr_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Reset while presenting with both banks full.
      for (int k = 0; k < N; k++) push(5, k == 0);
      for (int k = 0; k < N; k++) push(6, k == 0);
      check("pre_rst_valid", 32'(frame_valid), 32'd1);
      check("pre_rst_ready", 32'(llr_ready), 32'd0);
      rst = 1'b1;
      #1;
      check("rst_present_valid", 32'(frame_valid), 32'd0);
      check("rst_present_ready", 32'(llr_ready), 32'd1);
      check("rst_present_l_out", 32'(|l_out), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // A normal frame after reset.
      for (int k = 0; k < N; k++) push(k - 288, k == 0);
      @(negedge clk);
      check("post_rst_valid", 32'(frame_valid), 32'd1);
      check("post_rst_first", 32'(word(0)), 32'(w12(-288)));
      check("post_rst_last", 32'(word(N-1)), 32'(w12(287)));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
